// File: rtl/ccff_loader.sv
// ccff_loader: serialises host configuration words into a ccff scan chain.
// Words arrive through a valid/ready handshake and are shifted out MSB first
// on ccff_head. The chain advances only while ccff_en is high.
//
// Ports
//   prog_clk   programming clock, all state changes on its rising edge
//   prog_reset asynchronous active-low reset
//   start      one-cycle request to begin a chain load
//   abort      cancel the load in progress
//   cfg_data   configuration word (DATA_W bits, MSB shifted first)
//   cfg_valid  cfg_data valid
//   cfg_ready  loader can accept a word
//   ccff_head  serial bit to the chain head
//   ccff_en    chain shift enable
//   ccff_tail  serial bit from the chain tail
//   busy       load in progress (LOAD and SHIFT)
//   done       one-cycle pulse when a full chain load completes
//   err        sticky: start while busy or abort; cleared by an accepted start
//   rb_data    previous chain contents captured from ccff_tail
//
// Optional feature: define CCFF_LOADER_READBACK_EN to build the readback
// register. Without it rb_data is constant 0 and ccff_tail is unused.

module ccff_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CHAIN_LEN = 16
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 ccff_head,
    output logic                 ccff_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CHAIN_LEN-1:0] rb_data
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BIT_W-1:0]    word_cnt;
    logic [DATA_W-1:0]   shift_reg;

    // The shift register empties itself after DATA_W shifts and is cleared on
    // abort, so its MSB is a registered head bit that is 0 whenever ccff_en is 0.
    assign ccff_head = shift_reg[DATA_W-1];

    // Control FSM with registered outputs
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            cfg_ready <= 1'b0;
            ccff_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start wins over a simultaneous abort here
                    if (start) begin
                        state     <= S_LOAD;
                        bit_cnt   <= '0;
                        err       <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        shift_reg <= '0;
                        cfg_ready <= 1'b0;
                        ccff_en   <= 1'b0;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        if (start) begin
                            err <= 1'b1;
                        end
                        if (cfg_valid) begin
                            state     <= S_SHIFT;
                            shift_reg <= cfg_data;
                            word_cnt  <= '0;
                            cfg_ready <= 1'b0;
                            ccff_en   <= 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        shift_reg <= '0;
                        cfg_ready <= 1'b0;
                        ccff_en   <= 1'b0;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        if (start) begin
                            err <= 1'b1;
                        end
                        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        if (word_cnt == BIT_W'(DATA_W - 1)) begin
                            ccff_en <= 1'b0;
                            if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_LOAD;
                                cfg_ready <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + BIT_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_LOADER_READBACK_EN
    // Capture the previous chain contents as they fall out of the tail
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            rb_data <= '0;
        end else if (state == S_IDLE && start) begin
            rb_data <= '0;
        end else if (ccff_en) begin
            rb_data <= {rb_data[CHAIN_LEN-2:0], ccff_tail};
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed self-checking bench for ccff_loader (default parameters).
// A behavioural 16-flop chain closes the loop from ccff_head to ccff_tail.

module tb_ccff_loader;

    logic        prog_clk;
    logic        prog_reset;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ccff_head;
    logic        ccff_en;
    logic        ccff_tail;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rb_data;

    logic [15:0] chain;
    logic        e_err;
    int          total;
    int          bad;

    ccff_loader #(.DATA_W(8), .CHAIN_LEN(16)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .abort      (abort),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .ccff_head  (ccff_head),
        .ccff_en    (ccff_en),
        .ccff_tail  (ccff_tail),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rb_data    (rb_data)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Downstream chain model: shifts toward the tail only when enabled
    always @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) chain <= '0;
        else if (ccff_en) chain <= {chain[14:0], ccff_head};
    end
    assign ccff_tail = chain[15];

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic en_e, input logic head_e,
                       input logic rdy_e, input logic busy_e, input logic done_e);
        cmp({tag, ".en"},    32'(ccff_en),   32'(en_e));
        cmp({tag, ".head"},  32'(ccff_head), 32'(head_e));
        cmp({tag, ".ready"}, 32'(cfg_ready), 32'(rdy_e));
        cmp({tag, ".busy"},  32'(busy),      32'(busy_e));
        cmp({tag, ".done"},  32'(done),      32'(done_e));
        cmp({tag, ".err"},   32'(err),       32'(e_err));
    endtask

    // One chain load of two words. gap = cycles cfg_valid is withheld between
    // words; start_at/abort_at = bit index whose edge sees start (word 0) or
    // abort (word 1), -1 for none. prev = expected readback when enabled.
    task automatic run_load(input logic [15:0] val, input int gap, input int start_at,
                            input int abort_at, input logic chk_rb, input logic [15:0] prev);
        logic [7:0]  w [2];
        logic [15:0] exp_rb;
        int          t;
        w[0] = val[15:8];
        w[1] = val[7:0];
        t = 0;
`ifdef CCFF_LOADER_READBACK_EN
        exp_rb = prev;
`else
        exp_rb = 16'h0;
`endif
        cfg_data  = w[0];
        cfg_valid = 1'b1;
        start     = 1'b1;
        e_err     = 1'b0;
        tick(); t++;
        start = 1'b0;
        chk("load0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp("rb_clear", 32'(rb_data), 32'h0);
        for (int j = 0; j < 2; j++) begin
            for (int b = 0; b < 8; b++) begin
                if (j == 1 && b == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    e_err = 1'b1;
                    chk("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    for (int k = 0; k < 25; k++) begin
                        tick();
                        chk("post_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                    return;
                end
                if (j == 0 && b == start_at) start = 1'b1;
                tick(); t++;
                start = 1'b0;
                if (j == 0 && b == start_at) e_err = 1'b1;
                chk("shift", 1'b1, w[j][7-b], 1'b0, 1'b1, 1'b0);
                if (b == 0) begin
                    cfg_data  = w[1];
                    cfg_valid = (gap == 0);
                end
            end
            tick(); t++;
            if (j == 0) begin
                chk("between", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                for (int g = 0; g < gap; g++) begin
                    tick(); t++;
                    chk("gap", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                end
                cfg_valid = 1'b1;
            end else begin
                chk("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                cmp("done_cycle", 32'(t), 32'(19 + gap));
                cmp("chain", 32'(chain), 32'(val));
                if (chk_rb) cmp("rb_data", 32'(rb_data), 32'(exp_rb));
                cfg_valid = 1'b0;
                tick();
                chk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        e_err      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        cfg_data   = 8'h00;
        cfg_valid  = 1'b0;
        prog_reset = 1'b1;
        #1 prog_reset = 1'b0;
        #20;
        chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("reset.rb", 32'(rb_data), 32'h0);
        @(negedge prog_clk);
        prog_reset = 1'b1;
        tick();
        chk("post_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // basic load, valid held: bits 1010_0101_0011_1100, done at cycle 19
        run_load(16'hA53C, 0, -1, -1, 1'b1, 16'h0000);
        // 5-cycle hole between words delays done by 5
        run_load(16'hA53C, 5, -1, -1, 1'b1, 16'hA53C);
        // start during SHIFT of word 0: ignored, err set and sticky
        run_load(16'h5AF0, 0, 3, -1, 1'b1, 16'hA53C);
        // abort while word 1 shows its 3rd bit; the new start clears err first
        run_load(16'hC3C3, 0, -1, 3, 1'b0, 16'h0000);

        // reset mid-SHIFT
        cfg_data  = 8'h0F;
        cfg_valid = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        cmp("pre_reset.en", 32'(ccff_en), 32'h1);
        #2 prog_reset = 1'b0;
        #1;
        e_err = 1'b0;
        chk("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("async_reset.rb", 32'(rb_data), 32'h0);
        tick();
        chk("held_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge prog_clk);
        prog_reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cfg_valid = 1'b0;

        // readback sequence: chain starts cleared by reset
        run_load(16'hBEEF, 0, -1, -1, 1'b1, 16'h0000);
        run_load(16'h1234, 0, -1, -1, 1'b1, 16'hBEEF);
        run_load(16'h0000, 0, -1, -1, 1'b1, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
